// File: rtl/fifo_datapath.sv
// Storage and pointer datapath for the synchronous FIFO: register-file memory,
// wrap-bit pointers, occupancy count, registered read port and sticky error flags.
module fifo_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            control_signals,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [1:0]            status_signals,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr, rptr;
    logic load_data, read_data, clear, r_adr_trigger, w_adr_trigger;
    logic wr_req, rd_req, wr_acc, rd_acc, empty, full;

    assign {load_data, read_data, clear, r_adr_trigger, w_adr_trigger} = control_signals;

    assign wr_req = load_data & w_adr_trigger;
    assign rd_req = read_data & r_adr_trigger;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                   (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign status_signals = {empty, full};

    // A full FIFO still takes a write when a read frees the slot on the same edge.
    assign rd_acc = rd_req & ~empty;
    assign wr_acc = wr_req & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (rst && !clear && wr_acc)
            mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr     <= rptr + 1'b1;
            end
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (wr_acc && !rd_acc)
                count <= count + 1'b1;
            else if (rd_acc && !wr_acc)
                count <= count - 1'b1;
            if (wr_req && !wr_acc)
                overflow <= 1'b1;
            if (rd_req && !rd_acc)
                underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_datapath.sv
// Directed bench for fifo_datapath: queue-based reference model checked every
// cycle, plus literal expectations from hand-worked sequences.
module tb_fifo_datapath;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    control_signals = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [1:0]    status_signals;
    logic [AW:0]   count;
    logic          overflow, underflow;

    fifo_datapath #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .control_signals(control_signals), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .status_signals(status_signals),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: a queue of stored words and the rules of acceptance.
    int      q[$];
    logic [DW-1:0] m_dout = '0;
    bit      m_dv = 0, m_ovf = 0, m_udf = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0;
        end else if (control_signals[2]) begin
            q.delete();
            m_dv = 0; m_ovf = 0; m_udf = 0;
        end else begin
            bit wr, rd, rd_ok, wr_ok;
            wr = control_signals[4] && control_signals[0];
            rd = control_signals[3] && control_signals[1];
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
            m_dv = rd_ok;
            if (rd_ok) m_dout = DW'(q.pop_front());
            if (wr_ok) q.push_back(int'(data_in));
            if (wr && !wr_ok) m_ovf = 1;
            if (rd && !rd_ok) m_udf = 1;
        end
    end

    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_status", 32'(status_signals), {30'd0, q.size() == 0, q.size() == DEPTH});
        chk("m_dout", 32'(data_out), 32'(m_dout));
        chk("m_dv", 32'(data_valid), 32'(m_dv));
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
        chk("m_udf", 32'(underflow), 32'(m_udf));
    end

    task automatic cyc(input logic [4:0] c, input logic [DW-1:0] d);
        control_signals = c;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
        control_signals = '0;
    endtask

    localparam logic [4:0] WR = 5'b10001, RD = 5'b01010, BOTH = 5'b11011, CLR = 5'b00100;

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) cyc(5'b00000, 8'h00);
        chk("rst_status", 32'(status_signals), 32'h2);
        chk("rst_count", 32'(count), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_flags", {30'd0, overflow, underflow}, 0);

        // Partial control bits are no-ops
        cyc(5'b10000, 8'h77); cyc(5'b01000, 8'h00); cyc(5'b00001, 8'h77); cyc(5'b00010, 8'h00);
        chk("partial_count", 32'(count), 0);
        chk("partial_flags", {30'd0, overflow, underflow}, 0);

        for (int i = 1; i <= 16; i++) begin
            cyc(WR, DW'(i));
            chk("fill_count", 32'(count), 32'(i));
        end
        chk("full_status", 32'(status_signals), 32'h1);
        cyc(WR, 8'h99);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);

        for (int i = 1; i <= 16; i++) begin
            cyc(RD, 8'h00);
            chk("rd_dout", 32'(data_out), 32'(i));
            chk("rd_dv", 32'(data_valid), 1);
        end
        chk("empty_status", 32'(status_signals), 32'h2);
        cyc(RD, 8'h00);
        chk("udf_set", 32'(underflow), 1);
        chk("udf_dout", 32'(data_out), 32'h10);
        chk("udf_dv", 32'(data_valid), 0);

        // Pointer wrap
        cyc(CLR, 8'h00);
        for (int i = 0; i < 10; i++) cyc(WR, DW'(8'h30 + i));
        for (int i = 0; i < 10; i++) cyc(RD, 8'h00);
        chk("wrap_last", 32'(data_out), 32'h39);
        for (int i = 0; i < 16; i++) cyc(WR, DW'(8'hA0 + i));
        chk("wrap_full", 32'(status_signals), 32'h1);
        chk("wrap_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            cyc(RD, 8'h00);
            chk("wrap_rd", 32'(data_out), 32'(8'hA0 + i));
        end

        // Simultaneous read+write when full, then when empty
        for (int i = 1; i <= 16; i++) cyc(WR, DW'(8'h40 + i));
        cyc(BOTH, 8'h55);
        chk("both_full_count", 32'(count), 16);
        chk("both_full_dout", 32'(data_out), 32'h41);
        chk("both_full_status", 32'(status_signals), 32'h1);
        for (int i = 0; i < 16; i++) cyc(RD, 8'h00);
        chk("both_full_tail", 32'(data_out), 32'h55);
        cyc(BOTH, 8'h66);
        chk("both_empty_count", 32'(count), 1);
        chk("both_empty_udf", 32'(underflow), 1);
        chk("both_empty_dv", 32'(data_valid), 0);
        cyc(RD, 8'h00);
        chk("both_empty_rd", 32'(data_out), 32'h66);

        // Clear with flags set
        for (int i = 0; i < 5; i++) cyc(WR, DW'(i));
        cyc(CLR, 8'h00);
        chk("clr_count", 32'(count), 0);
        chk("clr_status", 32'(status_signals), 32'h2);
        chk("clr_flags", {30'd0, overflow, underflow}, 0);
        chk("clr_dout", 32'(data_out), 32'h66);

        // Asynchronous reset mid-read
        cyc(WR, 8'h11); cyc(WR, 8'h22);
        control_signals = RD;
        @(posedge clk);
        #2;
        chk("pre_rst_dv", 32'(data_valid), 1);
        rst = 1'b0;
        #1;
        chk("async_dv", 32'(data_valid), 0);
        chk("async_count", 32'(count), 0);
        chk("async_status", 32'(status_signals), 32'h2);
        chk("async_dout", 32'(data_out), 0);
        control_signals = '0;
        @(negedge clk);
        rst = 1'b1;
        cyc(5'b00000, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fifo_datapath.md
Name: fifo_datapath

Overview:
- Storage and pointer datapath for the synchronous FIFO.
- Sits directly downstream of the FIFO control FSM. It consumes the FSM's 5-bit control vector and returns the 2-bit pointer-status vector that the FSM uses for full detection.
- Holds a register-file memory, wrapping read/write address counters with a wrap bit, an occupancy counter, the registered read-data output, and sticky error flags.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries (16 by default).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- control_signals  input  5  {load_data, read_data, clear, r_adr_trigger, w_adr_trigger}, bit 4 down to bit 0.
- data_in  input  DATA_WIDTH  write data, sampled on a write edge.
- data_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  one-cycle pulse marking new data_out.
- status_signals  output  2  {r_adr_equal, w_adr_equal}; bit 1 = empty, bit 0 = full.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set on a rejected write.
- underflow  output  1  sticky; set on a rejected read.

Behaviour:
- Pointers
  - wptr and rptr are each ADDR_WIDTH+1 bits: an MSB wrap bit plus the address.
  - Address = low ADDR_WIDTH bits; increment wraps from DEPTH-1 to 0 and toggles the MSB.
- Status (combinational from registered pointers, no added latency)
  - r_adr_equal = (wptr == rptr), i.e. empty.
  - w_adr_equal = addresses equal AND MSBs differ, i.e. full.
- Write request (wr_req) = load_data & w_adr_trigger. Read request (rd_req) = read_data & r_adr_trigger.
- Write accept
  - Accepted when wr_req and (not full, or full with rd_req also accepted).
  - On accept: mem[wptr addr] <= data_in; wptr++ on the same edge.
- Read accept
  - Accepted when rd_req and not empty.
  - On accept: data_out <= mem[rptr addr]; rptr++; data_valid = 1 for the next cycle only.
  - Latency is 1 clock: data appears the cycle after the request edge.
- data_out holds its last value when no read is accepted; data_valid = 0 otherwise.
- Simultaneous write and read
  - When full: both accepted; count unchanged; write lands in the freed slot.
  - When empty: write accepted, read rejected (no fall-through); underflow set; count = 1.
  - Otherwise: both accepted; count unchanged.
- count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. It always equals wptr - rptr modulo 2*DEPTH.
- Rejected operations
  - A wr_req not accepted sets overflow.
  - A rd_req not accepted sets underflow.
  - Both flags are sticky until clear or reset.
- Partial control bits
  - load_data without w_adr_trigger, or read_data without r_adr_trigger, is a no-op.
  - Neither case sets an error flag.
- clear (bit 2)
  - Synchronous clear with priority over all other bits in that cycle.
  - Effect: wptr = rptr = 0, count = 0, overflow = underflow = 0, data_valid = 0.
  - data_out and memory contents are unchanged.
- Reset (rst = 0, asynchronous)
  - Outputs take these values immediately: wptr = rptr = 0, count = 0, data_out = 0, data_valid = 0, overflow = underflow = 0, status_signals = 2'b10.
  - Memory is not reset.
  - Reset mid-operation abandons any in-flight read; data_valid goes low at once.
- Deassertion of rst is expected to be synchronized upstream; the block takes no action on release.

Test Plan:
- Reset, then idle (control 5'b00000) for 3 cycles -> status_signals = 2'b10, count = 0, data_out = 0, data_valid = 0, no flags.
- Write 0x01..0x10 (16 words, control 5'b10001) -> count steps 1..16; after the 16th edge status_signals = 2'b01. A 17th write sets overflow = 1 and leaves count = 16 and wptr unchanged.
- From full, read 16 times (5'b01010) -> data_out = 0x01..0x10 in order, each one cycle after its request with a data_valid pulse. Final status_signals = 2'b10. A 17th read sets underflow = 1 and leaves data_out = 0x10.
- Fill 10, read 10, then write 0xA0..0xAF (16 words) -> pointer address wraps past 15; full asserts at count = 16; readback returns 0xA0..0xAF in order.
- Full FIFO with 5'b11011 and data_in = 0x55 -> count stays 16, data_out = oldest word, status stays full. Empty FIFO with 5'b11011 -> count = 1, underflow = 1, data_valid = 0.
- Fill 5 with flags set, apply 5'b00100 -> next cycle count = 0, status = 2'b10, flags = 0. Drop rst mid-read -> data_valid = 0 and count = 0 immediately, without waiting for a clock edge.
